ram_copy_dma: RTL and testbench

Initiator for the on-chip `ram` block's split read/write request/ack interface. It accepts a copy command (source address, destination address, word count) and moves that many words within the RAM, one word at a time. Each word is read, captured and written back before the next word starts. It sits between the SoC control logic and a `ram` instance, driving the RAM's `wr_*`/`rd_*` request ports.

---
 rtl/ram_copy_pkg.sv | 19 +
 rtl/ram_copy_wdog.sv | 41 ++++
 rtl/ram_copy_dma.sv | 155 +++++++++++++++
 tb/tb_ram_copy_dma.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared types and constants for the ram_copy_dma word-copy engine.
//   ram_copy_state_e     : FSM state encoding (IDLE..DONE)
//   DefaultTimeoutCycles : default ack wait limit when the timeout build option is on
//   CyclesPerWord        : cycles one word takes against a RAM that acks on the next edge
package ram_copy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } ram_copy_state_e;

  localparam int unsigned DefaultTimeoutCycles = 16;
  localparam int unsigned CyclesPerWord        = 4;

endpackage

// File: rtl/ram_copy_wdog.sv
// ram_copy_wdog: ack wait counter for ram_copy_dma.
//   clk_i, arstn_i : clock, synchronous active-low reset
//   clear          : restart the count (asserted the cycle before a wait state is entered)
//   enable         : a wait cycle passed without the expected ack
//   expired        : this wait cycle is the last one allowed; the engine must abort
module ram_copy_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the cycle the count would reach the limit, so the jump to DONE lands exactly
  // TIMEOUT_CYCLES cycles after the wait state was entered.
  assign expired = enable && (count_q == CntWidth'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_copy_dma.sv
// ram_copy_dma: copies cmd_len_i words inside a ram instance, one word at a time
// (read, capture, write) in ascending address order with wrap-around.
//   clk_i, arstn_i              : clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o   : command handshake; ready only while idle
//   cmd_src_i, cmd_dst_i        : first source / destination address
//   cmd_len_i                   : word count, zero is legal
//   busy_o, done_o, err_o       : busy from accept to done; done/err are one-cycle pulses
//   rd_o, rd_addr_o             : read request pulse and address
//   ack_rd_i, rd_data_i         : read ack with data in the same cycle
//   wr_o, wr_addr_o, wr_data_o  : write request pulse, address and data
//   ack_wr_i                    : write ack
// Build option: define RAM_COPY_TIMEOUT_EN to abort a command when an ack does not arrive
// within TIMEOUT_CYCLES; err_o then pulses with done_o. Without it waits are unbounded.
module ram_copy_dma
  import ram_copy_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_src_i,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rd_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic                  ack_rd_i,
  input  logic [WORD_WIDTH-1:0] rd_data_i,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [WORD_WIDTH-1:0] wr_data_o,
  input  logic                  ack_wr_i
);

  localparam int unsigned LenWidth = ADDR_WIDTH + 1;

  ram_copy_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  timeout_hit;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          src_d   = cmd_src_i;
          dst_d   = cmd_dst_i;
          len_d   = cmd_len_i;
          state_d = (cmd_len_i == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        // ack_wr_i is deliberately not looked at here
        if (ack_rd_i) begin
          data_d  = rd_data_i;
          state_d = StWrReq;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StWrReq: state_d = StWrWait;
      StWrWait: begin
        if (ack_wr_i) begin
          src_d   = src_q + ADDR_WIDTH'(1);
          dst_d   = dst_q + ADDR_WIDTH'(1);
          len_d   = len_q - LenWidth'(1);
          state_d = (len_q == LenWidth'(1)) ? StDone : StRdReq;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode straight from registered state so requests last exactly one cycle.
  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle) && (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign rd_o        = (state_q == StRdReq);
  assign rd_addr_o   = src_q;
  assign wr_o        = (state_q == StWrReq);
  assign wr_addr_o   = dst_q;
  assign wr_data_o   = data_q;

`ifdef RAM_COPY_TIMEOUT_EN
  logic wait_clear;
  logic wait_enable;
  logic err_q;

  // Clearing in the request state means the count starts at zero on entry to the wait.
  assign wait_clear  = (state_q == StRdReq) || (state_q == StWrReq);
  assign wait_enable = ((state_q == StRdWait) && !ack_rd_i) ||
                       ((state_q == StWrWait) && !ack_wr_i);

  ram_copy_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .clear  (wait_clear),
    .enable (wait_enable),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q && (state_q == StDone);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_ram_copy_dma.sv
module tb_ram_copy_dma;
  import ram_copy_pkg::*;

  localparam int unsigned WW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_len;
  logic          busy, done, err;
  logic          rd, wr;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WW-1:0] rd_data, wr_data;
  logic          ack_rd, ack_wr;

  // RAM model controls
  logic          spur_rd = 1'b0;
  logic          spur_wr = 1'b0;
  int            rd_lat  = 1;
  int            wr_lat  = 1;
  logic          pl_we   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [WW-1:0] pl_data = '0;

  logic [WW-1:0] mem     [16];
  logic [WW-1:0] ref_mem [16];
  logic [WW-1:0] rd_buf = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  logic [AW-1:0]    exp_rd [$];
  logic [AW+WW-1:0] exp_wr [$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  ram_copy_dma #(
    .WORD_WIDTH    (WW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_src_i  (cmd_src),
    .cmd_dst_i  (cmd_dst),
    .cmd_len_i  (cmd_len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .rd_o       (rd),
    .rd_addr_o  (rd_addr),
    .ack_rd_i   (ack_rd),
    .rd_data_i  (rd_data),
    .wr_o       (wr),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .ack_wr_i   (ack_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: samples a request on an edge and acks lat cycles later (lat 0 = never).
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (rd) begin
      rd_buf <= mem[rd_addr];
      rd_cnt <= rd_lat;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
    if (wr) begin
      mem[wr_addr] <= wr_data;
      wr_cnt       <= wr_lat;
    end else if (wr_cnt != 0) begin
      wr_cnt <= wr_cnt - 1;
    end
  end

  assign ack_rd  = (rd_cnt == 1) | spur_rd;
  assign ack_wr  = (wr_cnt == 1) | spur_wr;
  assign rd_data = rd_buf;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, need completion");
    $fatal(1);
  end

  task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Reference copy: ascending order, updates the shadow memory so overlap is modelled.
  task automatic push_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l);
    logic [AW-1:0] a, b;
    logic [WW-1:0] w;
    a = s;
    b = d;
    for (int i = 0; i < int'(l); i++) begin
      w = ref_mem[a];
      exp_rd.push_back(a);
      exp_wr.push_back({b, w});
      ref_mem[b] = w;
      a++;
      b++;
    end
  endtask

  // Offers a command until accepted; returns at the cycle after the accept cycle.
  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW:0] l, output int acc);
    acc = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Scoreboard consumer: pops expected requests as the DUT issues them, stops at done_o.
  task automatic run_to_done(input int budget, output int dcyc, output logic derr,
                             output int nrd, output int nwr);
    logic [AW-1:0]    er;
    logic [AW+WW-1:0] ew;
    dcyc = -1;
    derr = 1'b0;
    nrd  = 0;
    nwr  = 0;
    for (int i = 0; i < budget; i++) begin
      if (rd === 1'b1) begin
        nrd++;
        n_total++;
        if (exp_rd.size() == 0) begin
          $display("FAIL sb_rd: got unexpected read of addr %0d, need no read", rd_addr);
        end else begin
          er = exp_rd.pop_front();
          if (rd_addr !== er) $display("FAIL sb_rd: got addr %0d, need %0d", rd_addr, er);
          else n_pass++;
        end
      end
      if (wr === 1'b1) begin
        nwr++;
        n_total++;
        if (exp_wr.size() == 0) begin
          $display("FAIL sb_wr: got unexpected write %0d<=%0d, need no write", wr_addr, wr_data);
        end else begin
          ew = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== ew)
            $display("FAIL sb_wr: got %0d<=%0d, need %0d<=%0d", wr_addr, wr_data,
                     ew[AW+WW-1:WW], ew[WW-1:0]);
          else n_pass++;
        end
      end
      if (done === 1'b1) begin
        dcyc = cyc;
        derr = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    arstn     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({cmd_ready, busy, done, err, rd, wr} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b, need 100000", {cmd_ready, busy, done, err, rd, wr});
    else n_pass++;
    n_total++;
    if ({rd_addr, wr_addr, wr_data} !== '0)
      $display("FAIL reset_data: got %h, need 0", {rd_addr, wr_addr, wr_data});
    else n_pass++;
    arstn = 1'b1;
    for (int i = 0; i < 16; i++) preload(AW'(i), WW'(i) ^ WW'(10));
  endtask

  task automatic test_copy;
    int acc, dcyc, nrd, nwr;
    logic derr;
    preload(4'd2, 4'd5);
    preload(4'd3, 4'd6);
    preload(4'd4, 4'd7);
    push_cmd(4'd2, 4'd8, 5'd3);
    issue(4'd2, 4'd8, 5'd3, acc);
    n_total++;
    if ({busy, cmd_ready} !== 2'b10)
      $display("FAIL copy_busy: got busy,ready=%b, need 10", {busy, cmd_ready});
    else n_pass++;
    run_to_done(100, dcyc, derr, nrd, nwr);
    n_total++;
    if (dcyc - acc !== 13) $display("FAIL copy_latency: got %0d, need 13", dcyc - acc);
    else n_pass++;
    n_total++;
    if ({derr, busy, cmd_ready} !== 3'b000)
      $display("FAIL copy_done_flags: got err,busy,ready=%b, need 000", {derr, busy, cmd_ready});
    else n_pass++;
    n_total++;
    if ({mem[8], mem[9], mem[10]} !== {4'd5, 4'd6, 4'd7})
      $display("FAIL copy_mem: got %0d %0d %0d, need 5 6 7", mem[8], mem[9], mem[10]);
    else n_pass++;
    n_total++;
    if (nrd !== 3 || nwr !== 3 || exp_wr.size() !== 0)
      $display("FAIL copy_count: got rd=%0d wr=%0d left=%0d, need 3 3 0", nrd, nwr,
               exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_wrap;
    int acc, dcyc, nrd, nwr;
    logic derr;
    preload(4'd14, 4'd9);
    preload(4'd15, 4'd10);
    push_cmd(4'd14, 4'd0, 5'd3);
    issue(4'd14, 4'd0, 5'd3, acc);
    run_to_done(100, dcyc, derr, nrd, nwr);
    n_total++;
    if (dcyc - acc !== 13) $display("FAIL wrap_latency: got %0d, need 13", dcyc - acc);
    else n_pass++;
    n_total++;
    if ({mem[0], mem[1], mem[2]} !== {4'd9, 4'd10, 4'd9})
      $display("FAIL wrap_mem: got %0d %0d %0d, need 9 10 9", mem[0], mem[1], mem[2]);
    else n_pass++;
    n_total++;
    if (nrd !== 3 || exp_rd.size() !== 0)
      $display("FAIL wrap_reads: got rd=%0d left=%0d, need 3 0", nrd, exp_rd.size());
    else n_pass++;
  endtask

  task automatic test_zero_len;
    int acc, dcyc, nrd, nwr;
    logic derr;
    push_cmd(4'd5, 4'd6, 5'd0);
    issue(4'd5, 4'd6, 5'd0, acc);
    run_to_done(20, dcyc, derr, nrd, nwr);
    n_total++;
    if (dcyc - acc !== 1) $display("FAIL zero_latency: got %0d, need 1", dcyc - acc);
    else n_pass++;
    n_total++;
    if (nrd !== 0 || nwr !== 0 || derr !== 1'b0)
      $display("FAIL zero_reqs: got rd=%0d wr=%0d err=%b, need 0 0 0", nrd, nwr, derr);
    else n_pass++;
  endtask

  // Second command held on the port while busy; write acks hammered and reads slowed.
  task automatic test_back_to_back;
    int   acc_a, acc_b, done_a, done_b, nrd, nwr;
    logic derr;
    logic bad_idle;
    bad_idle = 1'b0;
    @(negedge clk);
    spur_rd = 1'b1;
    spur_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({cmd_ready, busy, rd, wr, done} !== 5'b10000) bad_idle = 1'b1;
    end
    n_total++;
    if (bad_idle !== 1'b0) $display("FAIL idle_acks: got a reaction to idle acks, need none");
    else n_pass++;
    spur_rd = 1'b0;
    rd_lat  = 3;
    push_cmd(4'd0, 4'd4, 5'd2);
    push_cmd(4'd8, 4'd12, 5'd2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src   = 4'd0;
    cmd_dst   = 4'd4;
    cmd_len   = 5'd2;
    acc_a     = cyc;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b, need 1", cmd_ready);
    else n_pass++;
    @(negedge clk);
    cmd_src = 4'd8;
    cmd_dst = 4'd12;
    run_to_done(100, done_a, derr, nrd, nwr);
    n_total++;
    if (done_a - acc_a !== 13) $display("FAIL b2b_latency_a: got %0d, need 13", done_a - acc_a);
    else n_pass++;
    @(negedge clk);
    acc_b = (cmd_ready === 1'b1) ? cyc : -1;
    n_total++;
    if (acc_b - done_a !== 1) $display("FAIL b2b_accept_gap: got %0d, need 1", acc_b - done_a);
    else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b0;
    run_to_done(100, done_b, derr, nrd, nwr);
    n_total++;
    if (done_b - acc_b !== 13) $display("FAIL b2b_latency_b: got %0d, need 13", done_b - acc_b);
    else n_pass++;
    n_total++;
    if (exp_wr.size() !== 0 || derr !== 1'b0)
      $display("FAIL b2b_left: got left=%0d err=%b, need 0 0", exp_wr.size(), derr);
    else n_pass++;
    spur_wr = 1'b0;
    rd_lat  = 1;
  endtask

  task automatic test_reset_mid;
    int   acc, dcyc, nrd, nwr, nd;
    logic derr;
    issue(4'd3, 4'd12, 5'd2, acc);
    @(negedge clk);
    n_total++;
    if ({busy, rd, wr} !== 3'b100)
      $display("FAIL mid_pre_state: got busy,rd,wr=%b, need 100", {busy, rd, wr});
    else n_pass++;
    arstn = 1'b0;
    @(negedge clk);
    n_total++;
    if ({cmd_ready, busy, done, err, rd, wr, rd_addr, wr_addr, wr_data} !==
        {6'b100000, {(2 * AW + WW){1'b0}}})
      $display("FAIL mid_reset_outs: got %h, need %h",
               {cmd_ready, busy, done, err, rd, wr, rd_addr, wr_addr, wr_data},
               {6'b100000, {(2 * AW + WW){1'b0}}});
    else n_pass++;
    arstn = 1'b1;
    nd    = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    n_total++;
    if (nd !== 0) $display("FAIL mid_no_done: got %0d done pulses, need 0", nd);
    else n_pass++;
    push_cmd(4'd3, 4'd12, 5'd2);
    issue(4'd3, 4'd12, 5'd2, acc);
    run_to_done(100, dcyc, derr, nrd, nwr);
    n_total++;
    if (dcyc - acc !== 9 || derr !== 1'b0)
      $display("FAIL mid_fresh_cmd: got latency %0d err %b, need 9 0", dcyc - acc, derr);
    else n_pass++;
  endtask

`ifdef RAM_COPY_TIMEOUT_EN
  task automatic test_timeout;
    int   acc, dcyc, nrd, nwr;
    logic derr;
    wr_lat = 0;
    push_cmd(4'd1, 4'd9, 5'd2);
    issue(4'd1, 4'd9, 5'd2, acc);
    run_to_done(100, dcyc, derr, nrd, nwr);
    n_total++;
    if (dcyc - (acc + int'(CyclesPerWord)) !== 16)
      $display("FAIL timeout_latency: got %0d, need 16", dcyc - (acc + int'(CyclesPerWord)));
    else n_pass++;
    n_total++;
    if (derr !== 1'b1) $display("FAIL timeout_err: got %b, need 1", derr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, err, cmd_ready} !== 3'b001)
      $display("FAIL timeout_after: got done,err,ready=%b, need 001", {done, err, cmd_ready});
    else n_pass++;
    exp_rd.delete();
    exp_wr.delete();
    wr_lat = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
`ifdef RAM_COPY_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
